split_mode_systolic_array: RTL and testbench
============================================

# split_mode_systolic_array

Parametrised output-stationary systolic matrix-multiply array with a run-time split mode. In full mode it computes one ROWS×COLS result tile. In split mode it cuts the data chains at the half-way row and column and computes four independent (ROWS/2)×(COLS/2) tiles. A start/feed/flush/drain controller, input skew buffers and a backpressured row-serial result drain are included. The block is the successor of the fixed roundabout array in the core's systolic layer.

## Interface
- DATA_WIDTH, 8: signed operand width.
- ACC_WIDTH, 32: signed accumulator width.
- ROWS, 4: PE rows; must be even and ≥2 (elaboration assert).
- COLS, 4: PE columns; must be even and ≥2 (elaboration assert).
- K_WIDTH, 8: width of the reduction-length field.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request; sampled only in IDLE.
- k_len  in  K_WIDTH  reduction length; latched with start.
- cfg_split  in  1  0 = full array, 1 = four quadrants; latched with start.
- busy  out  1  high in any state other than IDLE.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  high exactly while in FEED.
- a_in  in  DATA_WIDTH*ROWS  A column vector; lane i drives row i at column 0.
- b_in  in  DATA_WIDTH*COLS  B row vector; lane j drives column j at row 0.
- a_alt_in  in  DATA_WIDTH*ROWS  split mode only; lane i drives row i at column COLS/2.
- b_alt_in  in  DATA_WIDTH*COLS  split mode only; lane j drives column j at row ROWS/2.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row accepted.
- c_out  out  ACC_WIDTH*COLS  accumulators of row out_row.
- out_row  out  $clog2(ROWS)  index of the row being presented.
- out_last  out  1  high with the final row (ROWS-1).

## Operation
- FSM states: IDLE, FEED, FLUSH, DRAIN.
- IDLE → FEED on start, if k_len≠0. On the same edge: all accumulators and pass registers clear; k_len and cfg_split are latched.
- IDLE → DRAIN on start, if k_len=0. Accumulators clear, so the drain outputs zeros.
- FEED: a beat is accepted on in_valid && in_ready. If in_valid is low, zeros are injected and the beat counter holds. Zero operands leave the accumulators unchanged.
- FEED → FLUSH on the edge that accepts beat k_len. FLUSH injects zeros for ROWS+COLS-1 cycles, then goes to DRAIN.
- DRAIN presents rows 0..ROWS-1 in order. Each row holds until out_valid && out_ready. The edge that accepts row ROWS-1 returns to IDLE.
- Skew: primary A lane i is delayed i cycles; primary B lane j is delayed j cycles. A_alt lane i is delayed i+COLS/2; B_alt lane j is delayed j+ROWS/2. With these delays, PE(i,j) always sees a beat accepted at cycle t on cycle t+i+j+1, in either mode.
- Split mode: a PE at column COLS/2 takes A from a_alt_in, not from its left neighbour. A PE at row ROWS/2 takes B from b_alt_in, not from the PE above. Primary lanes are not consumed by the right/bottom halves.
- Full mode: alt inputs are ignored.
- Arithmetic: the DATA_WIDTH×DATA_WIDTH signed product is sign-extended to ACC_WIDTH and added. The sum wraps modulo 2^ACC_WIDTH; there is no saturation.
- start outside IDLE is ignored. in_valid outside FEED is ignored.
- Reset at any point forces IDLE and clears every register.

## Timing
- Reset values: busy, in_ready, out_valid, out_last 0; c_out 0; out_row 0.
- With no input gaps, the first out_valid rises k_len+ROWS+COLS-1 cycles after the first FEED cycle. Each input gap adds one cycle.
- Drain rows cost one cycle each when out_ready is held high.
- A new start is accepted the cycle after the final drain handshake. The minimum period is k_len+ROWS+COLS-1+ROWS+1 cycles.

## Structure
- Package `systolic_pkg` holds:
  - the state enum typedef `sa_state_t`;
  - the function `flush_cycles(rows, cols)`, which returns rows+cols-1;
  - the shared signed-width localparams.
- Sub-module `os_mac_pe` is one PE: A/B pass registers, clear, MAC accumulator, and a read port for the accumulator. The top level instantiates a generate grid of ROWS×COLS `os_mac_pe`, the skew delay lines, the split muxes and the FSM.

## Test plan
- Reset: assert rst mid-FEED. All outputs go to 0 and the FSM returns to IDLE. A following run with k_len=4 still produces correct results.
- Full mode, 4×4, k_len=4, A = I4, B = values 1..16 row-major, no gaps. Rows 0..3 of c_out equal B. The first out_valid is at cycle 11 after FEED entry.
- Same run with in_valid dropped on two cycles and out_ready toggling. Results are identical and out_valid rises at cycle 13.
- Signed/wrap: A=-128, B=127, k_len=2 gives -32512 in every element. With ACC_WIDTH=16, three beats of 127×127 give -17149 (wrapped).
- Split mode, 4×4, k_len=2, four distinct 2×2 products on primary and alt lanes. Each quadrant matches its reference. Driving garbage on a_in/b_in lanes of the right/bottom halves has no effect.
- start with k_len=0 drains four zero rows with out_last on row 3. start pulsed during DRAIN is ignored.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply layer.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    DRAIN
  } sa_state_t;

  // Cycles needed for the last beat to reach the far-corner PE.
  function automatic int unsigned flush_cycles(input int unsigned rows, input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/os_mac_pe.sv
// Output-stationary PE: forwards A right and B down, accumulates A*B locally.
module os_mac_pe
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] a_pass,
  output logic signed [DATA_WIDTH-1:0] b_pass,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  logic signed [2*DATA_WIDTH-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_pass <= '0;
      b_pass <= '0;
      acc    <= '0;
    end else if (clear) begin
      a_pass <= '0;
      b_pass <= '0;
      acc    <= '0;
    end else begin
      a_pass <= a;
      b_pass <= b;
      // Signed size cast sign-extends the product; the sum wraps.
      acc    <= acc + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/split_mode_systolic_array.sv
// ROWSxCOLS output-stationary systolic array with run-time quadrant split,
// input skew lines, feed/flush controller and row-serial result drain.
module split_mode_systolic_array
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [K_WIDTH-1:0]         k_len,
  input  logic                       cfg_split,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*ROWS-1:0] a_in,
  input  logic [DATA_WIDTH*COLS-1:0] b_in,
  input  logic [DATA_WIDTH*ROWS-1:0] a_alt_in,
  input  logic [DATA_WIDTH*COLS-1:0] b_alt_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH*COLS-1:0]  c_out,
  output logic [$clog2(ROWS)-1:0]    out_row,
  output logic                       out_last
);

  localparam int RH      = ROWS / 2;
  localparam int CH      = COLS / 2;
  localparam int RW      = $clog2(ROWS);
  localparam int FLUSH_N = int'(flush_cycles(ROWS, COLS));
  localparam int FW      = $clog2(FLUSH_N);

  if (ROWS < 2 || (ROWS % 2) != 0) begin : g_rows_check
    $error("ROWS must be even and >= 2");
  end
  if (COLS < 2 || (COLS % 2) != 0) begin : g_cols_check
    $error("COLS must be even and >= 2");
  end

  sa_state_t            state, state_next;
  logic [K_WIDTH-1:0]   k_reg, beat_cnt;
  logic                 split_reg;
  logic [FW-1:0]        flush_cnt;
  logic [RW-1:0]        row_cnt;
  logic                 accept, clear;

  assign in_ready  = (state == FEED);
  assign accept    = in_valid && in_ready;
  assign clear     = (state == IDLE) && start;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_row   = row_cnt;
  assign out_last  = out_valid && (row_cnt == RW'(ROWS - 1));

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = (k_len == '0) ? DRAIN : FEED;
      FEED:  if (accept && beat_cnt == k_reg - K_WIDTH'(1)) state_next = FLUSH;
      FLUSH: if (flush_cnt == FW'(FLUSH_N - 1)) state_next = DRAIN;
      DRAIN: if (out_ready && row_cnt == RW'(ROWS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_reg     <= '0;
      split_reg <= 1'b0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
    end else begin
      state <= state_next;
      if (clear) begin
        k_reg     <= k_len;
        split_reg <= cfg_split;
        beat_cnt  <= '0;
      end else if (accept) begin
        beat_cnt <= beat_cnt + K_WIDTH'(1);
      end
      flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
      if (state != DRAIN)  row_cnt <= '0;
      else if (out_ready)  row_cnt <= row_cnt + RW'(1);
    end
  end

  logic signed [DATA_WIDTH-1:0] a_skew [ROWS];
  logic signed [DATA_WIDTH-1:0] a_alt_skew [ROWS];
  logic signed [DATA_WIDTH-1:0] b_skew [COLS];
  logic signed [DATA_WIDTH-1:0] b_alt_skew [COLS];

  // Each lane is a packed shift line; the extra stage is the input capture
  // register, so a beat reaches PE(i,j) i+j+1 edges after acceptance.
  for (genvar i = 0; i < ROWS; i++) begin : g_a_lane
    localparam int PD = i + 1;
    localparam int AD = i + CH + 1;
    logic [DATA_WIDTH-1:0]    pri_new, alt_new;
    logic [PD*DATA_WIDTH-1:0] pri;
    logic [AD*DATA_WIDTH-1:0] alt;
    assign pri_new = accept ? a_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alt_new = accept ? a_alt_in[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pri <= '0;
        alt <= '0;
      end else if (clear) begin
        pri <= '0;
        alt <= '0;
      end else begin
        pri <= (PD*DATA_WIDTH)'({pri, pri_new});
        alt <= (AD*DATA_WIDTH)'({alt, alt_new});
      end
    end
    assign a_skew[i]     = pri[PD*DATA_WIDTH-1 -: DATA_WIDTH];
    assign a_alt_skew[i] = alt[AD*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  for (genvar j = 0; j < COLS; j++) begin : g_b_lane
    localparam int PD = j + 1;
    localparam int AD = j + RH + 1;
    logic [DATA_WIDTH-1:0]    pri_new, alt_new;
    logic [PD*DATA_WIDTH-1:0] pri;
    logic [AD*DATA_WIDTH-1:0] alt;
    assign pri_new = accept ? b_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign alt_new = accept ? b_alt_in[j*DATA_WIDTH +: DATA_WIDTH] : '0;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pri <= '0;
        alt <= '0;
      end else if (clear) begin
        pri <= '0;
        alt <= '0;
      end else begin
        pri <= (PD*DATA_WIDTH)'({pri, pri_new});
        alt <= (AD*DATA_WIDTH)'({alt, alt_new});
      end
    end
    assign b_skew[j]     = pri[PD*DATA_WIDTH-1 -: DATA_WIDTH];
    assign b_alt_skew[j] = alt[AD*DATA_WIDTH-1 -: DATA_WIDTH];
  end

  logic signed [DATA_WIDTH-1:0] a_pe [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_pe [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] a_pass [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_pass [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc [ROWS][COLS];

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_pe[i][j] = a_skew[i];
      end else if (j == CH) begin : g_a_split
        assign a_pe[i][j] = split_reg ? a_alt_skew[i] : a_pass[i][j-1];
      end else begin : g_a_chain
        assign a_pe[i][j] = a_pass[i][j-1];
      end

      if (i == 0) begin : g_b_edge
        assign b_pe[i][j] = b_skew[j];
      end else if (i == RH) begin : g_b_split
        assign b_pe[i][j] = split_reg ? b_alt_skew[j] : b_pass[i-1][j];
      end else begin : g_b_chain
        assign b_pe[i][j] = b_pass[i-1][j];
      end

      os_mac_pe #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .a     (a_pe[i][j]),
        .b     (b_pe[i][j]),
        .a_pass(a_pass[i][j]),
        .b_pass(b_pass[i][j]),
        .acc   (acc[i][j])
      );
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_out
    assign c_out[j*ACC_WIDTH +: ACC_WIDTH] = out_valid ? acc[row_cnt][j] : '0;
  end

endmodule

// File: tb/tb_split_mode_systolic_array.sv
// Directed + randomized bench for split_mode_systolic_array against a
// matrix-product reference model; a 16-bit-accumulator twin checks wrapping.
module tb_split_mode_systolic_array;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int C  = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_split = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0]      k_len = '0;
  logic [DW*R-1:0] a_in = '0, a_alt_in = '0;
  logic [DW*C-1:0] b_in = '0, b_alt_in = '0;

  logic        busy, in_ready, out_valid, out_last;
  logic [1:0]  out_row;
  logic [32*C-1:0] c_out;
  logic        busy16, in_ready16, out_valid16, out_last16;
  logic [1:0]  out_row16;
  logic [16*C-1:0] c_out16;

  int tests = 0;
  int fails = 0;
  int ap [16][R];
  int aa [16][R];
  int bp [16][C];
  int ba [16][C];

  always #5 clk = ~clk;

  split_mode_systolic_array #(
    .DATA_WIDTH(DW), .ACC_WIDTH(32), .ROWS(R), .COLS(C), .K_WIDTH(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .cfg_split(cfg_split),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .a_alt_in(a_alt_in), .b_alt_in(b_alt_in),
    .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out),
    .out_row(out_row), .out_last(out_last)
  );

  split_mode_systolic_array #(
    .DATA_WIDTH(DW), .ACC_WIDTH(16), .ROWS(R), .COLS(C), .K_WIDTH(8)
  ) dut16 (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .cfg_split(cfg_split),
    .busy(busy16), .in_valid(in_valid), .in_ready(in_ready16),
    .a_in(a_in), .b_in(b_in), .a_alt_in(a_alt_in), .b_alt_in(b_alt_in),
    .out_valid(out_valid16), .out_ready(out_ready), .c_out(c_out16),
    .out_row(out_row16), .out_last(out_last16)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C[i][j] = sum over beats of (A lane feeding row i) * (B lane feeding column j);
  // in split mode the right half uses alt A lanes and the bottom half alt B lanes.
  function automatic longint ref_c(input int i, input int j, input int k, input bit split);
    longint s = 0;
    for (int t = 0; t < k; t++) begin
      int av = (split && j >= C/2) ? aa[t][i] : ap[t][i];
      int bv = (split && i >= R/2) ? ba[t][j] : bp[t][j];
      s += longint'(av) * longint'(bv);
    end
    return s;
  endfunction

  task automatic fill_rand();
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < R; i++) begin
        ap[t][i] = int'($urandom_range(255)) - 128;
        aa[t][i] = int'($urandom_range(255)) - 128;
      end
      for (int j = 0; j < C; j++) begin
        bp[t][j] = int'($urandom_range(255)) - 128;
        ba[t][j] = int'($urandom_range(255)) - 128;
      end
    end
  endtask

  task automatic fill_const(input int av, input int bv);
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < R; i++) begin ap[t][i] = av; aa[t][i] = av; end
      for (int j = 0; j < C; j++) begin bp[t][j] = bv; ba[t][j] = bv; end
    end
  endtask

  task automatic drive_beat(input int beat);
    int v;
    for (int i = 0; i < R; i++) begin
      v = ap[beat][i]; a_in[i*DW +: DW] = v[7:0];
      v = aa[beat][i]; a_alt_in[i*DW +: DW] = v[7:0];
    end
    for (int j = 0; j < C; j++) begin
      v = bp[beat][j]; b_in[j*DW +: DW] = v[7:0];
      v = ba[beat][j]; b_alt_in[j*DW +: DW] = v[7:0];
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after the last drain.
  task automatic do_run(input int k, input bit split, input int gap_mask,
                        input bit ready_toggle, input bit poke_start, input int exp_first);
    int beat = 0, cyc = 0, row = 0, first = -1;
    bit done = 1'b0;
    logic [127:0] e32;
    logic [63:0]  e16;
    longint s;
    start = 1'b1; k_len = 8'(k); cfg_split = split;
    @(negedge clk);
    start = 1'b0;
    while (!done && cyc < 400) begin
      if (out_valid && first < 0) first = cyc;
      a_in = $urandom; b_in = $urandom; a_alt_in = $urandom; b_alt_in = $urandom;
      in_valid = in_ready ? 1'b0 : 1'($urandom_range(1));
      if (in_ready && !gap_mask[cyc % 32]) begin
        in_valid = 1'b1;
        drive_beat(beat);
        beat++;
      end
      start = poke_start && out_valid && row == 1;
      out_ready = ready_toggle ? cyc[0] : 1'b1;
      if (out_valid && out_ready) begin
        for (int j = 0; j < C; j++) begin
          s = ref_c(row, j, k, split);
          e32[j*32 +: 32] = s[31:0];
          e16[j*16 +: 16] = s[15:0];
        end
        chk($sformatf("c_out k=%0d split=%0d row=%0d", k, split, row), c_out, e32);
        chk($sformatf("c_out16 k=%0d row=%0d", k, row), c_out16, e16);
        chk($sformatf("row_tag row=%0d", row), {out_row, out_last}, {2'(row), row == R-1});
        row++;
        if (row == R) done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    chk("drain_done", done, 1'b1);
    chk($sformatf("first_valid k=%0d", k), first, exp_first);
    chk("idle_after_drain", {busy, in_ready, out_valid}, 3'b000);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", {busy, in_ready, out_valid, out_last, out_row, c_out}, '0);
    chk("reset_out16", {busy16, in_ready16, out_valid16, out_last16, out_row16, c_out16}, '0);
    rst = 1'b0;
    @(negedge clk);

    // Identity A, B = 1..16 row-major; alt lanes carry garbage in full mode.
    fill_rand();
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < R; i++) ap[t][i] = (i == t) ? 1 : 0;
      for (int j = 0; j < C; j++) bp[t][j] = t*4 + j + 1;
    end
    do_run(4, 1'b0, 0, 1'b0, 1'b0, 11);
    do_run(4, 1'b0, 32'h0000_000a, 1'b1, 1'b0, 13);

    fill_const(-128, 127);
    do_run(2, 1'b0, 0, 1'b0, 1'b0, 9);
    fill_const(127, 127);
    do_run(3, 1'b0, 0, 1'b0, 1'b0, 10);

    fill_rand();
    do_run(2, 1'b1, 0, 1'b0, 1'b0, 9);
    fill_rand();
    do_run(5, 1'b1, 32'h0000_0024, 1'b1, 1'b0, 14);
    fill_rand();
    do_run(9, 1'b0, 0, 1'b0, 1'b0, 16);

    do_run(0, 1'b0, 0, 1'b1, 1'b1, 0);

    // Reset in the middle of a feed, then a clean run.
    fill_rand();
    start = 1'b1; k_len = 8'd4; cfg_split = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 2; t++) begin
      in_valid = 1'b1;
      drive_beat(t);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    chk("reset_mid_feed", {busy, in_ready, out_valid, out_last, out_row, c_out}, '0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_rand();
    do_run(4, 1'b0, 0, 1'b1, 1'b0, 11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
